// File: rtl/simple_receiver.sv
// UART receive stage: oversamples an asynchronous serial line, recovers
// start/data/stop frames and pushes good words into a downstream FIFO.
module simple_receiver #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int WORD_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  full,
  output logic                  we,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDX_W       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WRITE,
    S_BREAK
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] r_dout;
  logic                  r_we;
  logic                  r_fe;
  logic                  r_ovr;
  logic                  r_sync1;
  logic                  r_sync2;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [WORD_WIDTH-1:0] w_shift_nxt;
  logic [WORD_WIDTH-1:0] w_dout_nxt;
  logic                  w_we_nxt;
  logic                  w_fe_nxt;
  logic                  w_ovr_nxt;
  logic                  w_rxs;

  assign w_rxs       = r_sync2;
  assign we          = r_we;
  assign dout        = r_dout;
  assign frame_error = r_fe;
  assign overrun     = r_ovr;

  // Synchronisers reset to the idle (high) line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_we    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_we    <= w_we_nxt;
      r_fe    <= w_fe_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_we_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_ovr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        // A start bit that is gone by mid-bit is treated as a glitch
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rxs;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets a directly following start bit be caught
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_fe_nxt    = 1'b1;
            w_state_nxt = S_BREAK;
          end else if (full) begin
            w_ovr_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        w_cnt_nxt   = '0;
        w_dout_nxt  = r_shift;
        w_we_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
